// File: rtl/rope_arbiter_if.sv
// Handshake bundle between the player/keyboard side, the rope mover and
// the rope arbiter. The arbiter connects through the slave modport.
interface rope_arbiter_if;
    logic        startOfFrame;
    logic [1:0]  fireReq;
    logic [10:0] player0X;
    logic [10:0] player1X;
    logic [10:0] ropeTopY;
    logic        ropeHitBall;
    logic        ropeActive;
    logic [10:0] ropeX;
    logic        ropeOwner;
    logic [1:0]  hitEvent;
    logic        busy;

    modport slave (
        input  startOfFrame, fireReq, player0X, player1X, ropeTopY, ropeHitBall,
        output ropeActive, ropeX, ropeOwner, hitEvent, busy
    );

    modport master (
        output startOfFrame, fireReq, player0X, player1X, ropeTopY, ropeHitBall,
        input  ropeActive, ropeX, ropeOwner, hitEvent, busy
    );
endinterface

// File: rtl/rope_arbiter.sv
// Rope arbiter: turns fire presses from two players into single rope shots,
// latches column/owner at grant, ends a shot on hit, ceiling or timeout and
// holds the rope inactive for a frame-counted cooldown between shots.
//
// state    | meaning
// IDLE     | no shot; grants the next clk when a request is pending
// ACTIVE   | rope travelling; exits on hit, ceiling or timeout
// COOLDOWN | rope held inactive so the mover returns to the floor
module rope_arbiter #(
    parameter int COOLDOWN_FRAMES = 4,
    parameter int TIMEOUT_FRAMES  = 90
) (
    input logic           clk,
    input logic           reset,
    rope_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST  = 8'(TIMEOUT_FRAMES - 1);
    localparam logic [7:0] COOLDOWN_LAST = 8'(COOLDOWN_FRAMES - 1);

    state_t      state_q, state_d;
    logic [1:0]  pending_q, pending_d;
    logic        last_owner_q, last_owner_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [1:0]  fire_prev_q, fire_prev_d;
    logic        active_q, active_d;
    logic [10:0] rope_x_q, rope_x_d;
    logic        owner_q, owner_d;
    logic [1:0]  hit_q, hit_d;

    logic [1:0]  fire_rise;
    logic        grantee;
    logic [1:0]  grant_mask;
    logic [7:0]  frame_inc;

    assign fire_rise  = bus.fireReq & ~fire_prev_q;
    // With both players waiting, the one who did not shoot last goes first.
    assign grantee    = (pending_q == 2'b11) ? ~last_owner_q : pending_q[1];
    assign grant_mask = grantee ? 2'b10 : 2'b01;
    assign frame_inc  = (frame_cnt_q == 8'hFF) ? frame_cnt_q : frame_cnt_q + 8'd1;

    // Next-state and next-output computation for the shot sequencer.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        last_owner_d = last_owner_q;
        frame_cnt_d  = frame_cnt_q;
        fire_prev_d  = bus.fireReq;
        active_d     = active_q;
        rope_x_d     = rope_x_q;
        owner_d      = owner_q;
        hit_d        = 2'b00;

        case (state_q)
            IDLE: begin
                if (pending_q != 2'b00) begin
                    pending_d    = (pending_q & ~grant_mask) | fire_rise;
                    owner_d      = grantee;
                    last_owner_d = grantee;
                    rope_x_d     = grantee ? bus.player1X : bus.player0X;
                    frame_cnt_d  = 8'd0;
                    active_d     = 1'b1;
                    state_d      = ACTIVE;
                end else begin
                    pending_d = pending_q | fire_rise;
                end
            end
            ACTIVE: begin
                // Presses during a shot are dropped; pending is left untouched.
                if (bus.ropeHitBall) begin
                    hit_d       = owner_q ? 2'b10 : 2'b01;
                    active_d    = 1'b0;
                    frame_cnt_d = 8'd0;
                    state_d     = COOLDOWN;
                end else if (bus.startOfFrame) begin
                    if ((bus.ropeTopY == 11'd0) || (frame_cnt_q == TIMEOUT_LAST)) begin
                        active_d    = 1'b0;
                        frame_cnt_d = 8'd0;
                        state_d     = COOLDOWN;
                    end else begin
                        frame_cnt_d = frame_inc;
                    end
                end
            end
            COOLDOWN: begin
                pending_d = pending_q | fire_rise;
                if (bus.startOfFrame) begin
                    if (frame_cnt_q == COOLDOWN_LAST) begin
                        frame_cnt_d = 8'd0;
                        state_d     = IDLE;
                    end else begin
                        frame_cnt_d = frame_inc;
                    end
                end
            end
            default: begin
                active_d    = 1'b0;
                frame_cnt_d = 8'd0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pending_q    <= 2'b00;
            last_owner_q <= 1'b1;
            frame_cnt_q  <= 8'd0;
            fire_prev_q  <= 2'b00;
            active_q     <= 1'b0;
            rope_x_q     <= 11'd0;
            owner_q      <= 1'b0;
            hit_q        <= 2'b00;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            last_owner_q <= last_owner_d;
            frame_cnt_q  <= frame_cnt_d;
            fire_prev_q  <= fire_prev_d;
            active_q     <= active_d;
            rope_x_q     <= rope_x_d;
            owner_q      <= owner_d;
            hit_q        <= hit_d;
        end
    end

    assign bus.ropeActive = active_q;
    assign bus.ropeX      = rope_x_q;
    assign bus.ropeOwner  = owner_q;
    assign bus.hitEvent   = hit_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_rope_arbiter.sv
// Bench for rope_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a shot-level model.
module tb_rope_arbiter;
    localparam int CD = 4;
    localparam int TO = 90;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rope_arbiter_if bus ();

    rope_arbiter #(.COOLDOWN_FRAMES(CD), .TIMEOUT_FRAMES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // Shot-level model: a shot is in flight, or a cooldown with frames left, or neither.
    logic        m_shot, m_cool;
    int          m_cool_left, m_frames;
    logic [1:0]  m_pend, m_prev, m_hit;
    logic        m_last, m_owner;
    logic [10:0] m_x;

    task automatic model_reset;
        m_shot = 0; m_cool = 0; m_cool_left = 0; m_frames = 0;
        m_pend = 0; m_prev = 0; m_hit = 0;
        m_last = 1; m_owner = 0; m_x = 0;
    endtask

    task automatic model_step;
        logic [1:0] rise;
        logic g;
        rise   = bus.fireReq & ~m_prev;
        m_prev = bus.fireReq;
        m_hit  = 2'b00;
        if (m_shot) begin
            if (bus.ropeHitBall) begin
                m_hit[m_owner] = 1'b1;
                m_shot = 0; m_cool = 1; m_cool_left = CD;
            end else if (bus.startOfFrame) begin
                m_frames++;
                if (bus.ropeTopY == 0 || m_frames == TO) begin
                    m_shot = 0; m_cool = 1; m_cool_left = CD;
                end
            end
        end else if (m_cool) begin
            m_pend |= rise;
            if (bus.startOfFrame) begin
                m_cool_left--;
                if (m_cool_left == 0) m_cool = 0;
            end
        end else if (m_pend != 0) begin
            g = (m_pend == 2'b11) ? !m_last : m_pend[1];
            m_pend[g] = 1'b0;
            m_pend |= rise;
            m_shot = 1; m_frames = 0;
            m_owner = g; m_last = g;
            m_x = g ? bus.player1X : bus.player0X;
        end else begin
            m_pend |= rise;
        end
    endtask

    task automatic compare_outputs;
        logic m_busy;
        m_busy = m_shot || m_cool;
        n_checks++;
        if (bus.ropeActive !== m_shot || bus.busy !== m_busy || bus.ropeX !== m_x ||
            bus.ropeOwner !== m_owner || bus.hitEvent !== m_hit) begin
            n_fail++;
            $display("FAIL cycle_compare t=%0t got act=%b busy=%b x=%0d own=%b hit=%b expected act=%b busy=%b x=%0d own=%b hit=%b",
                     $time, bus.ropeActive, bus.busy, bus.ropeX, bus.ropeOwner, bus.hitEvent,
                     m_shot, m_busy, m_x, m_owner, m_hit);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    always @(negedge clk) begin
        if (check_en && !reset) compare_outputs();
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic pulse_reset;
        #2 reset = 1'b1;
        #1 reset = 1'b0;
    endtask

    // Runs frames until busy drops; returns the number of frame pulses used.
    task automatic wait_idle(output int frames);
        frames = 0;
        while (bus.busy && frames < 200) begin
            bus.startOfFrame = 1'b1;
            cyc(1);
            bus.startOfFrame = 1'b0;
            frames++;
            if (bus.busy) cyc(1);
        end
        if (bus.busy) chk("wait_idle_bound", 1, 0);
    endtask

    task automatic hit_now;
        bus.ropeHitBall = 1'b1;
        cyc(1);
        bus.ropeHitBall = 1'b0;
    endtask

    initial begin
        int f;
        logic [1:0] last_hit;
        bus.startOfFrame = 0; bus.fireReq = 0; bus.ropeHitBall = 0;
        bus.player0X = 0; bus.player1X = 0; bus.ropeTopY = 11'd200;
        cyc(2);
        reset = 1'b0;
        check_en = 1'b1;
        cyc(1);
        chk("rst_active", int'(bus.ropeActive), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_x", int'(bus.ropeX), 0);
        chk("rst_owner", int'(bus.ropeOwner), 0);
        chk("rst_hit", int'(bus.hitEvent), 0);

        // Player 0 shot, hit on frame 10, cooldown length.
        bus.player0X = 11'd320; bus.fireReq = 2'b01;
        cyc(1);
        chk("t2_not_yet", int'(bus.ropeActive), 0);
        cyc(1);
        chk("t2_active", int'(bus.ropeActive), 1);
        chk("t2_x", int'(bus.ropeX), 320);
        chk("t2_owner", int'(bus.ropeOwner), 0);
        bus.fireReq = 2'b00; bus.player0X = 11'd5;
        repeat (9) begin
            bus.startOfFrame = 1'b1; cyc(1); bus.startOfFrame = 1'b0; cyc(2);
        end
        chk("t2_x_hold", int'(bus.ropeX), 320);
        bus.startOfFrame = 1'b1; bus.ropeHitBall = 1'b1;
        cyc(1);
        bus.startOfFrame = 1'b0; bus.ropeHitBall = 1'b0;
        chk("t2_hit", int'(bus.hitEvent), 1);
        chk("t2_drop", int'(bus.ropeActive), 0);
        cyc(1);
        chk("t2_hit_pulse", int'(bus.hitEvent), 0);
        wait_idle(f);
        chk("t2_cooldown_frames", f, CD);

        // Ceiling exit, then ceiling together with hit.
        bus.player0X = 11'd50; bus.fireReq = 2'b01;
        cyc(2);
        bus.fireReq = 2'b00; bus.ropeTopY = 11'd0;
        cyc(3);
        chk("t3_hold_no_sof", int'(bus.ropeActive), 1);
        bus.startOfFrame = 1'b1; cyc(1); bus.startOfFrame = 1'b0;
        chk("t3_ceiling", int'(bus.ropeActive), 0);
        chk("t3_no_hit", int'(bus.hitEvent), 0);
        bus.ropeTopY = 11'd200;
        wait_idle(f);
        bus.fireReq = 2'b01;
        cyc(2);
        bus.fireReq = 2'b00; bus.ropeTopY = 11'd0;
        bus.startOfFrame = 1'b1; bus.ropeHitBall = 1'b1;
        cyc(1);
        bus.startOfFrame = 1'b0; bus.ropeHitBall = 1'b0; bus.ropeTopY = 11'd200;
        chk("t3_hit_wins", int'(bus.hitEvent), 1);
        wait_idle(f);

        // Simultaneous presses after reset: round-robin from lastOwner=1.
        pulse_reset();
        bus.player0X = 11'd11; bus.player1X = 11'd777; bus.fireReq = 2'b11;
        cyc(2);
        chk("t4_first_owner", int'(bus.ropeOwner), 0);
        chk("t4_first_x", int'(bus.ropeX), 11);
        bus.fireReq = 2'b00;
        hit_now();
        chk("t4_hit", int'(bus.hitEvent), 1);
        wait_idle(f);
        cyc(1);
        chk("t4_second_active", int'(bus.ropeActive), 1);
        chk("t4_second_owner", int'(bus.ropeOwner), 1);
        chk("t4_second_x", int'(bus.ropeX), 777);

        // Press during ACTIVE is dropped.
        bus.fireReq = 2'b10; cyc(2); bus.fireReq = 2'b00; cyc(1);
        hit_now();
        chk("t5_hit_p1", int'(bus.hitEvent), 2);
        wait_idle(f);
        cyc(5);
        chk("t5_dropped", int'(bus.ropeActive), 0);
        chk("t5_dropped_busy", int'(bus.busy), 0);
        // Press during COOLDOWN is granted right after return to IDLE.
        bus.fireReq = 2'b01; cyc(2); bus.fireReq = 2'b00;
        hit_now();
        bus.startOfFrame = 1'b1; cyc(1); bus.startOfFrame = 1'b0;
        bus.fireReq = 2'b10; cyc(2); bus.fireReq = 2'b00;
        wait_idle(f);
        cyc(1);
        chk("t5_cd_grant", int'(bus.ropeActive), 1);
        chk("t5_cd_owner", int'(bus.ropeOwner), 1);
        hit_now();
        wait_idle(f);
        // Held button gives exactly one shot.
        bus.fireReq = 2'b01; cyc(2);
        chk("t5_held_shot", int'(bus.ropeActive), 1);
        hit_now();
        wait_idle(f);
        cyc(10);
        chk("t5_held_once", int'(bus.busy), 0);
        bus.fireReq = 2'b00; cyc(1);

        // Timeout with no hit and rope below ceiling.
        bus.fireReq = 2'b01; cyc(2); bus.fireReq = 2'b00;
        f = 0; last_hit = 2'b00;
        while (bus.ropeActive && f < 200) begin
            bus.startOfFrame = 1'b1; cyc(1); bus.startOfFrame = 1'b0;
            f++;
            last_hit = bus.hitEvent;
            cyc(1);
        end
        chk("t6_timeout_frames", f, TO);
        chk("t6_no_hit", int'(last_hit), 0);
        wait_idle(f);

        // Reset mid-shot, then reset during cooldown with a pending request.
        bus.player1X = 11'd900; bus.fireReq = 2'b10; cyc(2); bus.fireReq = 2'b00;
        chk("t1_pre_active", int'(bus.ropeActive), 1);
        #2 reset = 1'b1;
        #1;
        chk("t1_rst_active", int'(bus.ropeActive), 0);
        chk("t1_rst_busy", int'(bus.busy), 0);
        chk("t1_rst_x", int'(bus.ropeX), 0);
        chk("t1_rst_owner", int'(bus.ropeOwner), 0);
        reset = 1'b0;
        cyc(5);
        chk("t1_no_regrant", int'(bus.busy), 0);
        bus.fireReq = 2'b01; cyc(2); bus.fireReq = 2'b00;
        hit_now();
        bus.fireReq = 2'b10; cyc(2); bus.fireReq = 2'b00;
        pulse_reset();
        cyc(12);
        chk("t1_pending_cleared", int'(bus.busy), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bus.startOfFrame = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) bus.fireReq[0] = ~bus.fireReq[0];
            if ($urandom_range(0, 7) == 0) bus.fireReq[1] = ~bus.fireReq[1];
            bus.ropeHitBall = ($urandom_range(0, 15) == 0);
            bus.ropeTopY = ($urandom_range(0, 9) == 0) ? 11'd0 : 11'($urandom_range(1, 400));
            bus.player0X = 11'($urandom_range(0, 2047));
            bus.player1X = 11'($urandom_range(0, 2047));
            if ($urandom_range(0, 499) == 0) pulse_reset();
            cyc(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
